// File: rtl/pll_cntr_reconfig_ctrl.sv
// pll_cntr_reconfig_ctrl: shadowed PLL scale-counter settings applied by an ordered reset/switch/settle sequence
module pll_cntr_reconfig_ctrl #(
  parameter int NUM_CNTR = 6,
  parameter int RST_HOLD = 4,
  parameter int SETTLE   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [2:0]              cfg_sel,
  input  logic [7:0]              cfg_high,
  input  logic [7:0]              cfg_low,
  input  logic [7:0]              cfg_init,
  input  logic [1:0]              cfg_mode,
  input  logic                    apply,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [NUM_CNTR-1:0]     cntr_reset,
  output logic [8*NUM_CNTR-1:0]   cntr_high,
  output logic [8*NUM_CNTR-1:0]   cntr_low,
  output logic [8*NUM_CNTR-1:0]   cntr_init,
  output logic [2*NUM_CNTR-1:0]   cntr_mode
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SETTLE, S_DONE} state_t;
  localparam logic [25:0] DEF = {2'd1, 8'd1, 8'd1, 8'd1};
  state_t state, nxt;
  logic [15:0] cnt;
  logic [NUM_CNTR-1:0] dirty, mask, wr_vec, dirty_eff;
  logic idle, bad, wr_ok, start;
  logic [25:0] cfg_word;
  assign cfg_word = {cfg_mode, cfg_init, cfg_low, cfg_high};
  // DONE behaves like IDLE for new writes and applies
  assign idle = state == S_IDLE || state == S_DONE;
  assign busy = ~idle;
  assign cfg_ready = idle;
  assign done = state == S_DONE;
  assign cntr_reset = state == S_ASSERT ? mask : '0;
  assign bad = int'(cfg_sel) >= NUM_CNTR || (cfg_mode[1] && (cfg_high == 8'd0 || cfg_low == 8'd0));
  assign wr_ok = cfg_valid & idle & ~bad;
  // a write in the apply cycle joins the sequence
  assign dirty_eff = dirty | wr_vec;
  assign start = idle & apply & |dirty_eff;
  always_comb begin
    nxt = idle ? (apply ? (|dirty_eff ? S_ASSERT : S_DONE) : S_IDLE)
        : state == S_ASSERT ? (cnt == 16'(RST_HOLD - 1) ? S_SETTLE : S_ASSERT)
        : (cnt == 16'(SETTLE - 1) ? S_DONE : S_SETTLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      dirty   <= '0;
      mask    <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= nxt != state ? '0 : cnt + 16'd1;
      dirty   <= start ? '0 : dirty_eff;
      mask    <= start ? dirty_eff : mask;
      cfg_err <= cfg_valid & idle & bad;
    end
  end
  for (genvar i = 0; i < NUM_CNTR; i++) begin : g_cntr
    logic [25:0] sh, act;
    assign wr_vec[i] = wr_ok && cfg_sel == 3'(i);
    always_ff @(posedge clk) begin
      if (reset) begin
        sh  <= DEF;
        act <= DEF;
      end else begin
        if (wr_vec[i]) sh <= cfg_word;
        if (start && dirty_eff[i]) act <= wr_vec[i] ? cfg_word : sh;
      end
    end
    assign cntr_high[8*i+:8] = act[7:0];
    assign cntr_low[8*i+:8]  = act[15:8];
    assign cntr_init[8*i+:8] = act[23:16];
    assign cntr_mode[2*i+:2] = act[25:24];
  end
endmodule

// File: tb/tb_pll_cntr_reconfig_ctrl.sv
// tb_pll_cntr_reconfig_ctrl: randomized scoreboard bench with a settings-level reference model
module tb_pll_cntr_reconfig_ctrl;
  localparam int N = 6, RH = 4, ST = 16;
  logic clk = 0, reset = 1, cfg_valid = 0, apply = 0;
  logic [2:0] cfg_sel = 0;
  logic [7:0] cfg_high = 0, cfg_low = 0, cfg_init = 0;
  logic [1:0] cfg_mode = 0;
  logic cfg_ready, busy, done, cfg_err;
  logic [N-1:0] cntr_reset;
  logic [8*N-1:0] cntr_high, cntr_low, cntr_init;
  logic [2*N-1:0] cntr_mode;

  pll_cntr_reconfig_ctrl #(.NUM_CNTR(N), .RST_HOLD(RH), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_init(cfg_init),
    .cfg_mode(cfg_mode), .apply(apply), .busy(busy), .done(done), .cfg_err(cfg_err),
    .cntr_reset(cntr_reset), .cntr_high(cntr_high), .cntr_low(cntr_low),
    .cntr_init(cntr_init), .cntr_mode(cntr_mode));

  always #5 clk = ~clk;

  typedef struct {
    bit err;
    int start, lat, busy_len, rst_len;
    logic [N-1:0] mask;
    logic [63:0] h, l, i, m;
  } exp_t;
  exp_t q[$];

  int checks = 0, passes = 0, cyc = 0;
  int m_h[N], m_l[N], m_i[N], m_m[N];
  int s_h[N], s_l[N], s_i[N], s_m[N];
  bit m_dirty[N];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", name, act, exp);
  endtask

  function automatic logic [63:0] pk(int f);
    logic [63:0] v = 0;
    for (int k = 0; k < N; k++)
      case (f)
        0: v |= 64'(m_h[k] & 255) << (8 * k);
        1: v |= 64'(m_l[k] & 255) << (8 * k);
        2: v |= 64'(m_i[k] & 255) << (8 * k);
        default: v |= 64'(m_m[k] & 3) << (2 * k);
      endcase
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_h[k] = 1; m_l[k] = 1; m_i[k] = 1; m_m[k] = 1;
      s_h[k] = 1; s_l[k] = 1; s_i[k] = 1; s_m[k] = 1;
      m_dirty[k] = 0;
    end
  endfunction

  // returns 1 if the model accepts the write
  function automatic bit model_write(int sel, int h, int l, int ii, int m);
    if (sel >= N || (m >= 2 && (h == 0 || l == 0))) return 0;
    s_h[sel] = h; s_l[sel] = l; s_i[sel] = ii; s_m[sel] = m; m_dirty[sel] = 1;
    return 1;
  endfunction

  function automatic void model_apply();
    exp_t e;
    int nd = 0;
    e.err = 0; e.start = cyc; e.mask = 0;
    for (int k = 0; k < N; k++)
      if (m_dirty[k]) begin
        nd++; e.mask[k] = 1'b1;
        m_h[k] = s_h[k]; m_l[k] = s_l[k]; m_i[k] = s_i[k]; m_m[k] = s_m[k];
        m_dirty[k] = 0;
      end
    e.lat = nd > 0 ? RH + ST + 1 : 1;
    e.busy_len = nd > 0 ? RH + ST : 0;
    e.rst_len = nd > 0 ? RH : 0;
    e.h = pk(0); e.l = pk(1); e.i = pk(2); e.m = pk(3);
    q.push_back(e);
  endfunction

  function automatic void push_err();
    exp_t e;
    e = '{err: 1, start: cyc, lat: 0, busy_len: 0, rst_len: 0, mask: '0, h: 0, l: 0, i: 0, m: 0};
    q.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  int busy_n = 0, rst_n = 0;
  logic [N-1:0] rst_or = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_n = 0; rst_n = 0; rst_or = 0;
    end else begin
      if (busy) busy_n++;
      if (|cntr_reset) begin rst_n++; rst_or |= cntr_reset; end
      if (cfg_err) begin
        if (q.size() == 0) begin checks++; $display("FAIL unexpected_cfg_err at cycle %0d", cyc); end
        else begin e = q.pop_front(); chk("err_kind", 64'(e.err), 64'd1); end
      end
      if (done) begin
        if (q.size() == 0) begin checks++; $display("FAIL unexpected_done at cycle %0d", cyc); end
        else begin
          e = q.pop_front();
          chk("done_kind", 64'(e.err), 64'd0);
          chk("done_latency", 64'(cyc - e.start), 64'(e.lat));
          chk("busy_len", 64'(busy_n), 64'(e.busy_len));
          chk("reset_len", 64'(rst_n), 64'(e.rst_len));
          chk("reset_mask", 64'(rst_or), 64'(e.mask));
          chk("cntr_high", 64'(cntr_high), e.h);
          chk("cntr_low", 64'(cntr_low), e.l);
          chk("cntr_init", 64'(cntr_init), e.i);
          chk("cntr_mode", 64'(cntr_mode), e.m);
        end
        busy_n = 0; rst_n = 0; rst_or = 0;
      end
    end
  end

  task automatic drive_cfg(int sel, int h, int l, int ii, int m);
    cfg_sel = 3'(sel); cfg_high = 8'(h); cfg_low = 8'(l); cfg_init = 8'(ii); cfg_mode = 2'(m);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    if (!done) begin checks++; $display("FAIL done_timeout after %0d cycles", n); end
    @(posedge clk); #1;
  endtask

  task automatic wr(int sel, int h, int l, int ii, int m, bit with_apply = 0);
    drive_cfg(sel, h, l, ii, m);
    cfg_valid = 1; apply = with_apply;
    if (!model_write(sel, h, l, ii, m)) push_err();
    if (with_apply) model_apply();
    @(posedge clk); #1;
    cfg_valid = 0; apply = 0;
    if (with_apply) wait_done();
  endtask

  task automatic do_apply();
    apply = 1;
    model_apply();
    @(posedge clk); #1;
    apply = 0;
    wait_done();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_high", 64'(cntr_high), pk(0));
    chk("rst_low", 64'(cntr_low), pk(1));
    chk("rst_init", 64'(cntr_init), pk(2));
    chk("rst_mode", 64'(cntr_mode), pk(3));
    chk("rst_cntr_reset", 64'(cntr_reset), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd1);

    wr(2, 3, 2, 1, 2);
    @(posedge clk); #1;
    do_apply();

    wr(0, 9, 7, 4, 3);
    wr(5, 20, 10, 0, 2);
    do_apply();

    wr(7, 5, 5, 5, 1);
    wr(0, 0, 5, 1, 3);
    do_apply();

    wr(4, 11, 12, 13, 2, 1);

    wr(1, 6, 6, 2, 2);
    apply = 1;
    model_apply();
    @(posedge clk); #1;
    apply = 0;
    drive_cfg(3, 40, 41, 42, 3);
    cfg_valid = 1;
    chk("ready_while_busy", 64'(cfg_ready), 64'd0);
    repeat (4) @(posedge clk);
    #1 apply = 1;
    @(posedge clk); #1 apply = 0;
    begin
      int n = 0;
      bit r, taken = 0;
      while (!taken && n < 100) begin
        r = cfg_ready;
        @(posedge clk); #1;
        taken = r; n++;
      end
      if (!taken) begin checks++; $display("FAIL held_write_timeout after %0d cycles", n); end
    end
    cfg_valid = 0;
    void'(model_write(3, 40, 41, 42, 3));
    do_apply();

    for (int it = 0; it < 40; it++) begin
      int nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        wr($urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
           $urandom_range(0, 255), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0)
        wr($urandom_range(0, 7), $urandom_range(1, 255), $urandom_range(1, 255),
           $urandom_range(0, 255), $urandom_range(0, 3), 1);
      else do_apply();
    end

    wr(2, 50, 60, 70, 3);
    apply = 1;
    @(posedge clk); #1 apply = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    model_reset();
    chk("midrst_cntr_reset", 64'(cntr_reset), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_high", 64'(cntr_high), pk(0));
    chk("midrst_mode", 64'(cntr_mode), pk(3));
    repeat (30) @(posedge clk);
    #1 do_apply();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
